bf_iter_ctrl: RTL and testbench

- Sequential iteration controller for the bit-flipping LDPC decoder.
- Sits directly downstream of the 128-bit popcount tree: it consumes the 8-bit syndrome weight (number of unsatisfied checks) that the tree produces each decoder iteration.
- Decides whether to request another flip iteration, declare success (weight 0), or give up on the iteration limit or a stalled weight.
- Reports iteration count and best weight seen to the frame-level control.

---
 rtl/bf_iter_ctrl.sv | 132 +++++++++++++
 tb/tb_bf_iter_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_iter_ctrl.sv
// Iteration controller for the bit-flipping LDPC decoder: consumes per-iteration
// syndrome weights and decides between another flip, success, or giving up.
module bf_iter_ctrl #(
    parameter int WT_W      = 8,
    parameter int MAX_ITER  = 32,
    parameter int IT_W      = 6,
    parameter int STALL_LIM = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic            wt_valid,
    input  logic [WT_W-1:0] wt,
    output logic            iter_go,
    output logic            busy,
    output logic            done,
    output logic            success,
    output logic            stalled,
    output logic [IT_W-1:0] iter_cnt,
    output logic [WT_W-1:0] best_wt,
    output logic [1:0]      dbg_state
);

    // Handshake: wt is taken on any rising edge where wt_valid is high and the
    // controller sits in WAIT; there is no ready, so the producer must hold off
    // until the iter_go it triggered has been serviced.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [IT_W-1:0] iter_cnt_q, iter_cnt_d;
    logic [WT_W-1:0] best_wt_q, best_wt_d;
    logic [3:0]      stall_cnt_q, stall_cnt_d;
    logic            success_q, success_d;
    logic            stalled_q, stalled_d;
    logic [3:0]      stall_inc;
    logic            wt_better;

    assign wt_better = (wt < best_wt_q);
    assign stall_inc = (stall_cnt_q == 4'(STALL_LIM)) ? stall_cnt_q : stall_cnt_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        iter_cnt_d  = iter_cnt_q;
        best_wt_d   = best_wt_q;
        stall_cnt_d = stall_cnt_q;
        success_d   = success_q;
        stalled_d   = stalled_q;
        if (abort) begin
            // Abort freezes the frame statistics so they can be inspected afterwards.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d     = S_WAIT;
                        iter_cnt_d  = '0;
                        stall_cnt_d = '0;
                        success_d   = 1'b0;
                        stalled_d   = 1'b0;
                        best_wt_d   = '1;
                    end
                end
                S_WAIT: begin
                    if (wt_valid) begin
                        best_wt_d = wt_better ? wt : best_wt_q;
                        if (wt == '0) begin
                            success_d = 1'b1;
                            state_d   = S_FIN;
                        end else if (iter_cnt_q == IT_W'(MAX_ITER)) begin
                            state_d = S_FIN;
                        end else if (wt_better) begin
                            stall_cnt_d = '0;
                            state_d     = S_ISSUE;
                        end else begin
                            stall_cnt_d = stall_inc;
                            if (stall_inc == 4'(STALL_LIM)) begin
                                stalled_d = 1'b1;
                                state_d   = S_FIN;
                            end else begin
                                state_d = S_ISSUE;
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    iter_cnt_d = iter_cnt_q + 1'b1;
                    state_d    = S_WAIT;
                end
                S_FIN: begin
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            iter_cnt_q  <= '0;
            best_wt_q   <= '1;
            stall_cnt_q <= '0;
            success_q   <= 1'b0;
            stalled_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            iter_cnt_q  <= iter_cnt_d;
            best_wt_q   <= best_wt_d;
            stall_cnt_q <= stall_cnt_d;
            success_q   <= success_d;
            stalled_q   <= stalled_d;
        end
    end

    // Pulses are pure decodes of the state register, so they stay glitch-free
    // and have no path from the inputs.
    assign iter_go   = (state_q == S_ISSUE);
    assign busy      = (state_q == S_WAIT) || (state_q == S_ISSUE);
    assign done      = (state_q == S_FIN);
    assign success   = success_q;
    assign stalled   = stalled_q;
    assign iter_cnt  = iter_cnt_q;
    assign best_wt   = best_wt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bf_iter_ctrl.sv
// Directed bench for bf_iter_ctrl: a default instance plus a MAX_ITER=3 instance
// sharing the same stimulus, with a frame-outcome scoreboard on the default one.
module tb_bf_iter_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       wt_valid;
    logic [7:0] wt;

    logic       a_iter_go, a_busy, a_done, a_success, a_stalled;
    logic [5:0] a_iter_cnt;
    logic [7:0] a_best_wt;
    logic [1:0] a_state;

    logic       b_iter_go, b_busy, b_done, b_success, b_stalled;
    logic [5:0] b_iter_cnt;
    logic [7:0] b_best_wt;
    logic [1:0] b_state;

    int checks = 0;
    int errors = 0;
    int go_cnt = 0;
    int done_cnt = 0;

    // Outcome word: {success, stalled, iter_cnt, best_wt}
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];

    bf_iter_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .wt_valid(wt_valid), .wt(wt),
        .iter_go(a_iter_go), .busy(a_busy), .done(a_done),
        .success(a_success), .stalled(a_stalled),
        .iter_cnt(a_iter_cnt), .best_wt(a_best_wt), .dbg_state(a_state)
    );

    bf_iter_ctrl #(.MAX_ITER(3)) dut_m3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .wt_valid(wt_valid), .wt(wt),
        .iter_go(b_iter_go), .busy(b_busy), .done(b_done),
        .success(b_success), .stalled(b_stalled),
        .iter_cnt(b_iter_cnt), .best_wt(b_best_wt), .dbg_state(b_state)
    );

    // Clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Monitor: records pulses and frame outcomes of the default instance
    always @(negedge clk) begin
        if (a_iter_go) go_cnt++;
        if (a_done) begin
            done_cnt++;
            obs_q.push_back({a_success, a_stalled, a_iter_cnt, a_best_wt});
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] w);
        wt_valid = 1'b1;
        wt       = w;
        tick();
        wt_valid = 1'b0;
        wt       = 8'd0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_sb(input string tag);
        logic [15:0] o;
        logic [15:0] e;
        chk({tag, "_frames"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_outcome"}, 32'(o), 32'(e));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [15:0] outcome(input logic s, input logic st,
                                            input logic [5:0] it, input logic [7:0] bw);
        return {s, st, it, bw};
    endfunction

    initial begin
        logic [7:0] conv_w[3];
        logic [7:0] stall_w[5];
        logic [7:0] lim_w[3];
        int g0;
        int d0;

        conv_w  = '{8'd12, 8'd7, 8'd3};
        stall_w = '{8'd10, 8'd9, 8'd9, 8'd11, 8'd9};
        lim_w   = '{8'd20, 8'd19, 8'd18};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; wt_valid = 1'b0; wt = 8'd0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_state",   32'(a_state), 0);
        chk("rst_busy",    32'(a_busy), 0);
        chk("rst_iter_go", 32'(a_iter_go), 0);
        chk("rst_done",    32'(a_done), 0);
        chk("rst_flags",   32'({a_success, a_stalled}), 0);
        chk("rst_iter",    32'(a_iter_cnt), 0);
        chk("rst_best",    32'(a_best_wt), 255);

        // Clean frame: initial weight 0
        g0 = go_cnt;
        exp_q.push_back(outcome(1'b1, 1'b0, 6'd0, 8'd0));
        pulse_start();
        chk("clean_busy", 32'(a_busy), 1);
        chk("clean_best_init", 32'(a_best_wt), 255);
        feed(8'd0);
        chk("clean_done", 32'(a_done), 1);
        chk("clean_busy_fin", 32'(a_busy), 0);
        tick();
        chk("clean_done_once", 32'(a_done), 0);
        chk("clean_success_held", 32'(a_success), 1);
        chk("clean_no_go", 32'(go_cnt - g0), 0);
        check_sb("clean");

        // wt_valid with wt=0 while IDLE is ignored
        feed(8'd0);
        chk("idle_wt_state", 32'(a_state), 0);
        chk("idle_wt_done", 32'(a_done), 0);

        // Converging frame with ignored start in WAIT and wt_valid in ISSUE
        g0 = go_cnt;
        exp_q.push_back(outcome(1'b1, 1'b0, 6'd3, 8'd0));
        pulse_start();
        chk("conv_success_clr", 32'(a_success), 0);
        for (int i = 0; i < 3; i++) begin
            feed(conv_w[i]);
            chk($sformatf("conv_go_%0d", i), 32'(a_iter_go), 1);
            chk($sformatf("conv_iter_%0d", i), 32'(a_iter_cnt), 32'(i));
            if (i == 1) begin
                // Sampled in ISSUE: must not end the frame
                wt_valid = 1'b1;
                wt = 8'd0;
                tick();
                wt_valid = 1'b0;
                chk("issue_wt_ignored", 32'(a_state), 1);
                pulse_start();
                chk("wait_start_iter", 32'(a_iter_cnt), 2);
                chk("wait_start_best", 32'(a_best_wt), 7);
            end else begin
                tick();
            end
        end
        feed(8'd0);
        chk("conv_done", 32'(a_done), 1);
        tick();
        chk("conv_go_count", 32'(go_cnt - g0), 3);
        check_sb("conv");

        // Stall frame: 10 9 9 11 9 9 with STALL_LIM=4
        exp_q.push_back(outcome(1'b0, 1'b1, 6'd5, 8'd9));
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            feed(stall_w[i]);
            chk($sformatf("stall_go_%0d", i), 32'(a_iter_go), 1);
            tick();
        end
        feed(8'd9);
        chk("stall_done", 32'(a_done), 1);
        chk("stall_flag", 32'(a_stalled), 1);
        tick();
        check_sb("stall");

        // Iteration limit on the MAX_ITER=3 instance: 20 19 18 17
        pulse_start();
        chk("lim_stalled_clr", 32'(a_stalled), 0);
        for (int i = 0; i < 3; i++) begin
            feed(lim_w[i]);
            tick();
        end
        feed(8'd17);
        chk("lim_done", 32'(b_done), 1);
        chk("lim_iter", 32'(b_iter_cnt), 3);
        chk("lim_best", 32'(b_best_wt), 17);
        chk("lim_flags", 32'({b_success, b_stalled}), 0);
        chk("lim_dflt_continues", 32'(a_iter_go), 1);
        tick();
        chk("lim_held_iter", 32'(b_iter_cnt), 3);
        chk("lim_idle", 32'(b_state), 0);

        // Abort the default instance in WAIT: no done, stats held
        d0 = done_cnt;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort1_state", 32'(a_state), 0);
        chk("abort1_iter", 32'(a_iter_cnt), 4);
        chk("abort1_best", 32'(a_best_wt), 17);

        // Abort after two iterations, then restart clears
        pulse_start();
        feed(8'd50); tick();
        feed(8'd40); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_state", 32'(a_state), 0);
        chk("abort_busy", 32'(a_busy), 0);
        chk("abort_iter", 32'(a_iter_cnt), 2);
        chk("abort_best", 32'(a_best_wt), 40);
        tick();
        chk("abort_no_done", 32'(done_cnt - d0), 0);
        pulse_start();
        chk("restart_iter", 32'(a_iter_cnt), 0);
        chk("restart_best", 32'(a_best_wt), 255);
        chk("restart_busy", 32'(a_busy), 1);

        // Asynchronous reset while in ISSUE
        feed(8'd30);
        chk("pre_rst_go", 32'(a_iter_go), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_go", 32'(a_iter_go), 0);
        chk("arst_busy", 32'(a_busy), 0);
        chk("arst_state", 32'(a_state), 0);
        chk("arst_best", 32'(a_best_wt), 255);
        chk("arst_iter", 32'(b_iter_cnt), 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", 32'(a_state), 0);
        check_sb("tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
